// File: rtl/rf_pkg.sv
// Shared widths and the write-request record for the GPR write-port arbiter.
package rf_pkg;

    localparam int unsigned REG_AW   = 5;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NUM_REGS = 32;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] addr;
        logic [DATA_W-1:0] data;
    } wreq_t;

endpackage

// File: rtl/rf_wport_arbiter_if.sv
// Write-port bus: pipeline writeback, LMU valid/ready result and the resulting RF write.
interface rf_wport_arbiter_if;
    import rf_pkg::*;

    logic              wb_valid;
    logic [REG_AW-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              lmu_valid;
    logic [REG_AW-1:0] lmu_addr;
    logic [DATA_W-1:0] lmu_data;
    logic              lmu_ready;
    logic              rf_we;
    logic [REG_AW-1:0] rf_wa;
    logic [DATA_W-1:0] rf_wd;

    modport master (
        output wb_valid, wb_addr, wb_data, lmu_valid, lmu_addr, lmu_data,
        input  lmu_ready, rf_we, rf_wa, rf_wd
    );

    modport slave (
        input  wb_valid, wb_addr, wb_data, lmu_valid, lmu_addr, lmu_data,
        output lmu_ready, rf_we, rf_wa, rf_wd
    );

endinterface

// File: rtl/rf_scoreboard.sv
// Busy vector of GPRs awaiting an LMU result, with read/WAW hazard lookup.
module rf_scoreboard
    import rf_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_en,
    input  logic [REG_AW-1:0] set_addr,
    input  logic              clr_en,
    input  logic [REG_AW-1:0] clr_addr,
    input  logic [REG_AW-1:0] ra1,
    input  logic [REG_AW-1:0] ra2,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_addr,
    output logic              hazard
);

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [NUM_REGS-1:0] set_mask, clr_mask;

    // Set is applied after clear so a re-issue to the completing register stays busy.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en) set_mask[set_addr] = 1'b1;
        if (clr_en) clr_mask[clr_addr] = 1'b1;
        busy_d    = (busy_q & ~clr_mask) | set_mask;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    assign hazard = busy_q[ra1] | busy_q[ra2] | (wb_valid & busy_q[wb_addr]);

endmodule

// File: rtl/rf_wport_arbiter.sv
// GPR write-port arbiter: writeback priority, LMU starvation guard, scoreboard hazards.
// Define RF_ARB_PERF_EN to add the perf_conflicts / perf_starves counters.
module rf_wport_arbiter
    import rf_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned CNT_W      = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    rf_wport_arbiter_if.slave  bus,
    input  logic               iss_valid,
    input  logic [REG_AW-1:0]  iss_addr,
    input  logic [REG_AW-1:0]  ra1,
    input  logic [REG_AW-1:0]  ra2,
    output logic               hazard_stall,
    output logic               starve_stall
`ifdef RF_ARB_PERF_EN
    ,
    output logic [31:0]        perf_conflicts,
    output logic [31:0]        perf_starves
`endif
);

    wreq_t wb_req, lmu_req, wr;
    logic  lmu_ready;

    // Writeback always wins; nothing is granted while reset is held.
    always_comb begin
        wb_req    = '{valid: bus.wb_valid,  addr: bus.wb_addr,  data: bus.wb_data};
        lmu_req   = '{valid: bus.lmu_valid, addr: bus.lmu_addr, data: bus.lmu_data};
        wr        = '0;
        lmu_ready = 1'b0;
        if (rst_n) begin
            if (wb_req.valid) begin
                wr = wb_req;
            end else if (lmu_req.valid) begin
                wr        = lmu_req;
                lmu_ready = 1'b1;
            end
        end
    end

    assign bus.rf_we     = wr.valid;
    assign bus.rf_wa     = wr.addr;
    assign bus.rf_wd     = wr.data;
    assign bus.lmu_ready = lmu_ready;

    rf_scoreboard u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (iss_valid & (iss_addr != '0)),
        .set_addr (iss_addr),
        .clr_en   (lmu_ready),
        .clr_addr (bus.lmu_addr),
        .ra1      (ra1),
        .ra2      (ra2),
        .wb_valid (bus.wb_valid),
        .wb_addr  (bus.wb_addr),
        .hazard   (hazard_stall)
    );

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             starve_q, starve_d;

    // The stall is raised at the same edge the counter saturates and held until the LMU is served.
    always_comb begin
        cnt_d = '0;
        if (bus.lmu_valid && !lmu_ready) begin
            cnt_d = (cnt_q == CNT_W'(STARVE_MAX)) ? cnt_q : cnt_q + CNT_W'(1);
        end
        starve_d = lmu_ready ? 1'b0 : (starve_q | (cnt_d == CNT_W'(STARVE_MAX)));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            starve_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
        end
    end

    assign starve_stall = starve_q;

`ifdef RF_ARB_PERF_EN
    logic [31:0] conflicts_q, starves_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            conflicts_q <= '0;
            starves_q   <= '0;
        end else begin
            if (bus.wb_valid && bus.lmu_valid) conflicts_q <= conflicts_q + 32'd1;
            if (starve_d && !starve_q)         starves_q   <= starves_q + 32'd1;
        end
    end

    assign perf_conflicts = conflicts_q;
    assign perf_starves   = starves_q;
`endif

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Self-checking bench for rf_wport_arbiter: directed scenarios then constrained-random traffic.
module tb_rf_wport_arbiter;

    localparam int SM = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       iss_valid;
    logic [4:0] iss_addr, ra1, ra2;
    logic       hazard_stall, starve_stall;
`ifdef RF_ARB_PERF_EN
    logic [31:0] perf_conflicts, perf_starves;
`endif

    rf_wport_arbiter_if bus ();

    rf_wport_arbiter #(.STARVE_MAX(SM), .CNT_W(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .iss_valid    (iss_valid),
        .iss_addr     (iss_addr),
        .ra1          (ra1),
        .ra2          (ra2),
        .hazard_stall (hazard_stall),
        .starve_stall (starve_stall)
`ifdef RF_ARB_PERF_EN
        ,
        .perf_conflicts (perf_conflicts),
        .perf_starves   (perf_starves)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: pending-result set, length of the current refusal streak, stall flag.
    bit          busy_m [32];
    int          streak   = 0;
    bit          starve_m = 1'b0;
    int unsigned m_conf   = 0;
    int unsigned m_starv  = 0;

    logic        s_we, s_ready, s_hz, s_st;
    logic [4:0]  s_wa;
    logic [31:0] s_wd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        foreach (busy_m[i]) busy_m[i] = 1'b0;
        streak   = 0;
        starve_m = 1'b0;
        m_conf   = 0;
        m_starv  = 0;
    endtask

    // One clock: check outputs at negedge against the model, advance the model at posedge.
    task automatic cycle();
        logic        e_we, e_ready, e_hz;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        bit          prev;
        @(negedge clk);
        e_we    = rst_n && (bus.wb_valid || bus.lmu_valid);
        e_ready = rst_n && !bus.wb_valid && bus.lmu_valid;
        e_wa    = '0;
        e_wd    = '0;
        if (rst_n && bus.wb_valid) begin
            e_wa = bus.wb_addr;
            e_wd = bus.wb_data;
        end else if (rst_n && bus.lmu_valid) begin
            e_wa = bus.lmu_addr;
            e_wd = bus.lmu_data;
        end
        e_hz = busy_m[ra1] || busy_m[ra2] || (bus.wb_valid && busy_m[bus.wb_addr]);
        s_we    = bus.rf_we;
        s_wa    = bus.rf_wa;
        s_wd    = bus.rf_wd;
        s_ready = bus.lmu_ready;
        s_hz    = hazard_stall;
        s_st    = starve_stall;
        chk("rf_we", s_we, e_we);
        chk("rf_wa", s_wa, e_wa);
        chk("rf_wd", s_wd, e_wd);
        chk("lmu_ready", s_ready, e_ready);
        chk("hazard_stall", s_hz, e_hz);
        chk("starve_stall", s_st, starve_m);
`ifdef RF_ARB_PERF_EN
        chk("perf_conflicts", perf_conflicts, m_conf);
        chk("perf_starves", perf_starves, m_starv);
`endif
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (bus.wb_valid && bus.lmu_valid) m_conf++;
            if (e_ready) busy_m[bus.lmu_addr] = 1'b0;
            if (iss_valid && iss_addr != 0) busy_m[iss_addr] = 1'b1;
            if (bus.lmu_valid && !e_ready) streak = (streak < SM) ? streak + 1 : SM;
            else                           streak = 0;
            prev = starve_m;
            if (e_ready)           starve_m = 1'b0;
            else if (streak == SM) starve_m = 1'b1;
            if (starve_m && !prev) m_starv++;
        end
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.wb_valid  = 1'b0; bus.wb_addr  = '0; bus.wb_data  = '0;
        bus.lmu_valid = 1'b0; bus.lmu_addr = '0; bus.lmu_data = '0;
        iss_valid = 1'b0; iss_addr = '0; ra1 = '0; ra2 = '0;
        model_reset();
        @(posedge clk);
        #1;

        // Reset held: requests are not granted.
        bus.wb_valid = 1'b1; bus.lmu_valid = 1'b1;
        cycle();
        chk("rst_we_held", s_we, 1'b0);
        chk("rst_ready_held", s_ready, 1'b0);
        bus.wb_valid = 1'b0; bus.lmu_valid = 1'b0;
        cycle();

        // 1. Idle after reset.
        rst_n = 1'b1;
        cycle();
        chk("idle_we", s_we, 1'b0);
        chk("idle_hz", s_hz, 1'b0);
        chk("idle_st", s_st, 1'b0);

        // 2. Collision then LMU grant.
        bus.wb_valid = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'h11;
        bus.lmu_valid = 1'b1; bus.lmu_addr = 5'd9; bus.lmu_data = 32'h22;
        cycle();
        chk("col_wa", s_wa, 5'd5);
        chk("col_ready", s_ready, 1'b0);
        bus.wb_valid = 1'b0;
        cycle();
        chk("lmu_wa", s_wa, 5'd9);
        chk("lmu_wd", s_wd, 32'h22);
        chk("lmu_ready", s_ready, 1'b1);
        bus.lmu_valid = 1'b0;

        // 3. Scoreboard RAW on r8, and issue to r0 never stalls.
        iss_valid = 1'b1; iss_addr = 5'd8;
        cycle();
        iss_valid = 1'b0; ra1 = 5'd8;
        cycle();
        chk("sb_hz_set", s_hz, 1'b1);
        bus.lmu_valid = 1'b1; bus.lmu_addr = 5'd8; bus.lmu_data = 32'h88;
        cycle();
        chk("sb_hz_wr", s_hz, 1'b1);
        bus.lmu_valid = 1'b0;
        cycle();
        chk("sb_hz_clr", s_hz, 1'b0);
        iss_valid = 1'b1; iss_addr = 5'd0; ra1 = 5'd0;
        cycle();
        iss_valid = 1'b0;
        cycle();
        chk("sb_r0", s_hz, 1'b0);

        // 4. Starvation: four refused cycles raise the stall.
        bus.wb_valid = 1'b1; bus.wb_addr = 5'd1; bus.wb_data = 32'hAA;
        bus.lmu_valid = 1'b1; bus.lmu_addr = 5'd7; bus.lmu_data = 32'h77;
        repeat (4) cycle();
        chk("starve_early", s_st, 1'b0);
        bus.wb_valid = 1'b0;
        cycle();
        chk("starve_set", s_st, 1'b1);
        chk("starve_grant", s_ready, 1'b1);
        bus.lmu_valid = 1'b0;
        cycle();
        chk("starve_clr", s_st, 1'b0);

        // 5. Same-cycle complete and re-issue of r3.
        iss_valid = 1'b1; iss_addr = 5'd3;
        cycle();
        bus.lmu_valid = 1'b1; bus.lmu_addr = 5'd3; bus.lmu_data = 32'h33;
        cycle();
        iss_valid = 1'b0; bus.lmu_valid = 1'b0; ra1 = 5'd3;
        cycle();
        chk("setclr_busy", s_hz, 1'b1);
        bus.lmu_valid = 1'b1; ra1 = 5'd0;
        cycle();
        bus.lmu_valid = 1'b0;

        // 6. Reset with r12 busy and two refusals pending.
        iss_valid = 1'b1; iss_addr = 5'd12;
        cycle();
        iss_valid = 1'b0;
        bus.wb_valid = 1'b1; bus.lmu_valid = 1'b1; bus.lmu_addr = 5'd4;
        repeat (2) cycle();
        rst_n = 1'b0; bus.wb_valid = 1'b0; bus.lmu_valid = 1'b0;
        cycle();
        rst_n = 1'b1; ra1 = 5'd12;
        cycle();
        chk("rst_busy_clr", s_hz, 1'b0);
        bus.wb_valid = 1'b1; bus.lmu_valid = 1'b1;
        repeat (4) cycle();
        chk("rst_cnt_clr", s_st, 1'b0);
        bus.wb_valid = 1'b0;
        cycle();
        chk("rst_cnt_full", s_st, 1'b1);
        bus.lmu_valid = 1'b0;

        // Random traffic honouring the pipeline and LMU protocols.
        for (int i = 0; i < 400; i++) begin
            rst_n        = ($urandom_range(0, 63) != 0);
            bus.wb_valid = !starve_m && ($urandom_range(0, 1) == 1);
            bus.wb_addr  = 5'($urandom);
            bus.wb_data  = $urandom;
            if (!rst_n) begin
                bus.lmu_valid = 1'b0;
            end else if (!bus.lmu_valid || s_ready) begin
                bus.lmu_valid = ($urandom_range(0, 2) != 0);
                bus.lmu_addr  = 5'($urandom);
                bus.lmu_data  = $urandom;
            end
            iss_valid = ($urandom_range(0, 3) == 0);
            iss_addr  = 5'($urandom);
            ra1       = 5'($urandom);
            ra2       = 5'($urandom);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
